// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one variable-latency multiplier among N_REQ requesters.
// Define MUL_SHARE_CONST_TIME_EN to make response latency independent of operand values.
module mul_share_sched #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned TIMEOUT     = 7,
  localparam int unsigned IdW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned CntW       = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IdW-1:0]           resp_id,
  output logic [2*WIDTH-1:0]       resp_result,
  output logic                     resp_err,
  output logic                     mul_in_valid,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_out_valid,
  input  logic [2*WIDTH-1:0]       mul_result,
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       rr_q, rr_d;
  logic [IdW-1:0]       grant_q, grant_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic                 gnt_found;
  logic [IdW-1:0]       gnt_idx;
  logic [IdW-1:0]       cand;
  int unsigned          idx;
  logic                 got;

  // First asserted request at or above rr_q, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IdW'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    err_d        = err_q;
    done_d       = done_q;
    cnt_d        = cnt_q;
    req_ready    = '0;
    mul_in_valid = 1'b0;
    got          = done_q | mul_out_valid;
    unique case (state_q)
      StIdle: begin
        if (gnt_found && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          grant_d = gnt_idx;
          a_d     = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
          b_d     = req_b[32'(gnt_idx)*WIDTH +: WIDTH];
          res_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        mul_in_valid = 1'b1;
        cnt_d        = CntW'(1);
        state_d      = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_out_valid && !done_q) begin
          res_d  = mul_result;
          done_d = 1'b1;
        end
`ifdef MUL_SHARE_CONST_TIME_EN
        // Early results are held until the worst-case latency has elapsed.
        if (got && cnt_q >= CntW'(MUL_LATENCY)) begin
`else
        if (mul_out_valid) begin
`endif
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT) && !got) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          rr_d    = (grant_q == IdW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_valid  = (state_q == StResp);
  assign resp_id     = grant_q;
  assign resp_result = res_q;
  assign resp_err    = err_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mul_share_sched.sv
// Randomized bench for mul_share_sched with a behavioural multiplier and transaction-level model.
module tb_mul_share_sched;
  localparam int unsigned WIDTH       = 4;
  localparam int unsigned N_REQ       = 4;
  localparam int unsigned MUL_LATENCY = 2;
  localparam int unsigned TIMEOUT     = 7;
  localparam int unsigned IdW         = 2;
  localparam int unsigned AW          = N_REQ * WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid, req_ready;
  logic [AW-1:0]        req_a, req_b;
  logic                 resp_valid, resp_ready, resp_err;
  logic [IdW-1:0]       resp_id;
  logic [2*WIDTH-1:0]   resp_result;
  logic                 mul_in_valid, mul_out_valid, busy;
  logic [WIDTH-1:0]     mul_a, mul_b;
  logic [2*WIDTH-1:0]   mul_result;

  mul_share_sched #(
    .WIDTH(WIDTH), .N_REQ(N_REQ), .MUL_LATENCY(MUL_LATENCY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err),
    .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out_valid(mul_out_valid), .mul_result(mul_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int off;
  int rr_m;
  int exp_id, exp_lat;
  logic [WIDTH-1:0]   exp_a, exp_b;
  logic [2*WIDTH-1:0] exp_res;
  logic               exp_err;
  bit                 mul_pend, cfg_never;
  int                 mul_done, cfg_lat;
  logic [2*WIDTH-1:0] mul_prod;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; the multiplier model reacts on the falling edge.
  task automatic step();
    int l;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    mul_out_valid = 1'b0;
    mul_result    = (2*WIDTH)'($urandom);
    if (mul_pend && cyc == mul_done) begin
      mul_out_valid = 1'b1;
      mul_result    = mul_prod;
      mul_pend      = 1'b0;
    end
    if (mul_in_valid) begin
      l        = (mul_a == 0 || mul_b == 0) ? 1 : cfg_lat;
      mul_prod = mul_a * mul_b;
      mul_done = cyc + l;
      mul_pend = !cfg_never;
    end
  endtask

  task automatic start_txn(input logic [N_REQ-1:0] mask, input int lat, input bit never,
                           input bit use_f, input int fa, input int fb);
    int eff;
    bit found;
    cfg_lat   = lat;
    cfg_never = never;
    found     = 0;
    exp_id    = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && mask[(rr_m + i) % N_REQ]) begin
        found  = 1;
        exp_id = (rr_m + i) % N_REQ;
      end
    end
    req_a = AW'($urandom);
    req_b = AW'($urandom);
    if (use_f) begin
      req_a[exp_id*WIDTH +: WIDTH] = WIDTH'(fa);
      req_b[exp_id*WIDTH +: WIDTH] = WIDTH'(fb);
    end
    req_valid = mask;
    exp_a = req_a[exp_id*WIDTH +: WIDTH];
    exp_b = req_b[exp_id*WIDTH +: WIDTH];
    eff   = (exp_a == 0 || exp_b == 0) ? 1 : lat;
    if (never) begin
      exp_lat = 2 + TIMEOUT;
      exp_err = 1'b1;
      exp_res = '0;
    end else begin
`ifdef MUL_SHARE_CONST_TIME_EN
      exp_lat = 2 + MUL_LATENCY;
`else
      exp_lat = 2 + eff;
`endif
      exp_err = 1'b0;
      exp_res = (2*WIDTH)'(int'(exp_a) * int'(exp_b));
    end
    #1;
    check("req_ready", 32'(req_ready), 32'(1 << exp_id));
    step();
    off = 1;
    req_valid = '0;
  endtask

  task automatic wait_resp();
    while (!resp_valid && off < 40) begin
      check("mul_in_valid", 32'(mul_in_valid), 32'(off == 1));
      check("busy", 32'(busy), 32'd1);
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("mul_a_hold", 32'(mul_a), 32'(exp_a));
      check("mul_b_hold", 32'(mul_b), 32'(exp_b));
      req_a = AW'($urandom);
      req_b = AW'($urandom);
      step();
      off++;
    end
    check("resp_latency", 32'(off), 32'(exp_lat));
    check("resp_id", 32'(resp_id), 32'(exp_id));
    check("resp_result", 32'(resp_result), 32'(exp_res));
    check("resp_err", 32'(resp_err), 32'(exp_err));
  endtask

  task automatic finish_resp(input int hold);
    for (int i = 0; i < hold; i++) begin
      step();
      check("resp_hold_valid", 32'(resp_valid), 32'd1);
      check("resp_hold_busy", 32'(busy), 32'd1);
      check("resp_hold_result", 32'(resp_result), 32'(exp_res));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_done_valid", 32'(resp_valid), 32'd0);
    check("resp_done_busy", 32'(busy), 32'd0);
    rr_m = (exp_id + 1) % N_REQ;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    check({tag, "_resp_result"}, 32'(resp_result), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_mul_in_valid"}, 32'(mul_in_valid), 32'd0);
    check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    mul_pend = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_stale_resp", 32'(resp_valid), 32'd0);
      check("no_stale_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    mul_out_valid = 1'b0;
    mul_result = '0;
    mul_pend = 1'b0;
    cfg_never = 1'b0;
    cfg_lat = 2;
    rr_m = 0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Directed: 3*5 from requester 1, then zero-operand fast path against a normal operand.
    start_txn(4'b0010, 2, 0, 1, 3, 5);
    wait_resp();
    finish_resp(0);
    start_txn(4'b1111, 2, 0, 1, 0, 9);
    wait_resp();
    finish_resp(1);
    start_txn(4'b1111, 2, 0, 1, 2, 9);
    wait_resp();
    finish_resp(0);

    // All requesters held: grant order must rotate and wrap.
    for (int i = 0; i < 5; i++) begin
      start_txn(4'b1111, int'($urandom_range(1, MUL_LATENCY)), 0, 0, 0, 0);
      wait_resp();
      finish_resp(int'($urandom_range(0, 2)));
    end

    // Multiplier that never answers.
    start_txn(4'b0100, 2, 1, 0, 0, 0);
    wait_resp();
    finish_resp(3);

    // Stray result pulse while idle must be ignored.
    mul_out_valid = 1'b1;
    mul_result = 8'hAA;
    step();
    check("stray_resp_valid", 32'(resp_valid), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      start_txn(N_REQ'($urandom_range(1, 15)), int'($urandom_range(1, MUL_LATENCY)),
                ($urandom_range(0, 7) == 0), 0, 0, 0);
      wait_resp();
      finish_resp(int'($urandom_range(0, 2)));
    end

    // Reset mid-WAIT, then in RESP with resp_ready low.
    start_txn(4'b0010, 2, 0, 0, 0, 0);
    step();
    async_reset("rst_wait");
    start_txn(4'b0010, 2, 0, 1, 7, 3);
    wait_resp();
    async_reset("rst_resp");
    start_txn(4'b1111, 2, 0, 1, 4, 4);
    wait_resp();
    finish_resp(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Scheduler that shares one variable-latency MUL unit among N_REQ requesters.
- Arbitrates round-robin, issues one operation at a time and holds the operands stable while MUL works.
- Returns the result to the granting requester, with a watchdog timeout.
- Sits between requester ports and the shared MUL. Its optional constant-time mode removes the operand-dependent timing from the response path.

Parameters:
- WIDTH, 4, operand width; results are 2*WIDTH bits.
- N_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 2, worst-case MUL latency in cycles, counted from the issue cycle to the mul_out_valid cycle.
- TIMEOUT, 7, watchdog cycle limit in WAIT; must be greater than MUL_LATENCY.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester operation request
- req_ready  out  N_REQ  one-hot accept; a requester's operation is taken when its req_valid and req_ready are both 1
- req_a  in  N_REQ*WIDTH  operand A of requester i, at bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing as req_a
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts the response
- resp_id  out  $clog2(N_REQ)  index of the requester being answered
- resp_result  out  2*WIDTH  product
- resp_err  out  1  response produced by the watchdog timeout
- mul_in_valid  out  1  issue pulse to MUL
- mul_a  out  WIDTH  operand A to MUL
- mul_b  out  WIDTH  operand B to MUL
- mul_out_valid  in  1  MUL result valid
- mul_result  in  2*WIDTH  MUL product
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, cnt=0; all outputs 0. Any in-flight operation is dropped with no response. The same rst drives the MUL.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the first asserted req_valid searching upward from rr_ptr, with wrap-around.
  - req_ready[grant]=1 combinationally in the same cycle; on that edge latch the operands and grant id, then go to ISSUE.
  - With no request, stay in IDLE and keep req_ready=0.
- ISSUE: mul_in_valid=1 for exactly this one cycle. Set cnt=1 and go to WAIT.
- WAIT:
  - mul_a/mul_b stay held from the latch through ISSUE and WAIT, because MUL samples its operands every cycle.
  - cnt increments each cycle.
  - When mul_out_valid=1, capture mul_result into resp_result and set the done flag.
  - Exit condition is set by the optional feature.
  - Watchdog: if cnt==TIMEOUT and no result has been captured, go to RESP with resp_err=1 and resp_result=0.
- RESP:
  - resp_valid=1; resp_id and resp_result stay stable.
  - On resp_ready: go to IDLE and set rr_ptr=(grant+1) mod N_REQ.
  - resp_valid with no resp_ready holds indefinitely.
- Timing: accept at cycle 0, ISSUE at cycle 1. MUL with actual latency L raises mul_out_valid at cycle 1+L. resp_valid rises at cycle 2+L, or at cycle 2+MUL_LATENCY in constant-time mode.
- MUL completes in 1..MUL_LATENCY cycles; it takes 1 cycle when either operand is 0.
- Simultaneous events:
  - A requester deasserting req_valid while not granted is legal.
  - mul_out_valid outside WAIT is ignored.
  - mul_out_valid in the same cycle cnt==TIMEOUT counts as a result, not a timeout.
- Only one operation is outstanding at a time; req_ready is 0 outside IDLE.

Optional Feature:
- Macro: MUL_SHARE_CONST_TIME_EN.
- Defined:
  - WAIT exits only when cnt==MUL_LATENCY and the result is captured; an early result is held.
  - resp_valid therefore always rises exactly MUL_LATENCY+2 cycles after accept, independent of operand values.
  - If the result is missing at MUL_LATENCY, wait for it under the watchdog.
- Undefined: WAIT exits in the cycle mul_out_valid=1, so response latency tracks MUL latency.

Test Plan:
- Reset, then req_valid[1]=1, a=3, b=5, model MUL L=2 -> req_ready=4'b0010 at cycle 0; mul_in_valid only at cycle 1; resp_valid at cycle 4 with resp_id=1, resp_result=15, resp_err=0.
- a=0, b=9, model MUL L=1 -> result 0. resp_valid at cycle 3 without the macro; at cycle 4 with MUL_SHARE_CONST_TIME_EN. Compare against a=2, b=9 (result 18, cycle 4 in both builds).
- req_valid=4'b1111 held, resp_ready=1 -> grants in order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- MUL model never asserts mul_out_valid -> resp_valid with resp_err=1 and resp_result=0 after TIMEOUT cycles in WAIT; busy stays 1 until resp_ready.
- rst pulsed mid-WAIT and again in RESP with resp_ready=0 -> all outputs 0 immediately (async); next request is granted from rr_ptr=0; no stale response appears.
- mul_a/mul_b are checked every cycle from ISSUE to WAIT exit while the requester changes req_a/req_b -> values stay equal to the latched operands.
